// File: rtl/alu_arbiter.sv
// -----------------------------------------------------------------------------
// alu_arbiter
//   Round-robin arbiter between two requesters that share one ALU. The block
//   has a single result register. An accepted operation is computed in the
//   cycle it is accepted, and its result is registered at that same edge.
//
// Parameters
//   WIDTH        operand/result width in bits (default 4)
//
// Ports
//   clk, rst_n                   clock; asynchronous active-low reset
//   reqN_valid / reqN_ready      request handshake for requester N (N = 0, 1)
//   reqN_a, reqN_b, reqN_op      operands and op (00 add, 01 sub, 10 and, 11 or)
//   res_valid / res_ready        result handshake
//   res_data, res_id             registered result and the requester that owns it
//   res_carry, res_zero          flags; present only with ALU_ARBITER_FLAGS_EN
//
// Build option
//   ALU_ARBITER_FLAGS_EN  when defined, adds the res_carry and res_zero outputs.
//                         res_carry is the add carry-out or the subtract
//                         borrow. It is 0 for the logic ops.
// -----------------------------------------------------------------------------
module alu_arbiter #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic [1:0]       req0_op,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    input  logic [1:0]       req1_op,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [WIDTH-1:0] res_data,
    output logic             res_id
`ifdef ALU_ARBITER_FLAGS_EN
    ,
    output logic             res_carry,
    output logic             res_zero
`endif
);

    typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

    state_t           state_q, state_d;
    logic             prio_q, prio_d;          // 1: requester 1 wins a tie
    logic [WIDTH-1:0] res_data_q, res_data_d;
    logic             res_id_q, res_id_d;

    logic             can_accept, grant1;
    logic             req0_xfer, req1_xfer, req_xfer, res_xfer;
    logic [WIDTH-1:0] sel_a, sel_b, alu_res;
    logic [1:0]       sel_op;

    // Ready signals depend only on the valids, res_ready, state and reset.
    // Gating with rst_n keeps both readies low while reset is held.
    always_comb begin
        can_accept = rst_n && ((state_q == EMPTY) || res_ready);
        grant1     = req1_valid && (!req0_valid || prio_q);
        req0_ready = can_accept && req0_valid && !grant1;
        req1_ready = can_accept && grant1;
        req0_xfer  = req0_valid && req0_ready;
        req1_xfer  = req1_valid && req1_ready;
        req_xfer   = req0_xfer || req1_xfer;
        res_valid  = (state_q == FULL);
        res_xfer   = res_valid && res_ready;
    end

    // Operand mux and ALU. Every result wraps modulo 2^WIDTH.
    always_comb begin
        sel_a   = req1_xfer ? req1_a  : req0_a;
        sel_b   = req1_xfer ? req1_b  : req0_b;
        sel_op  = req1_xfer ? req1_op : req0_op;
        alu_res = '0;
        case (sel_op)
            2'b00:   alu_res = sel_a + sel_b;
            2'b01:   alu_res = sel_a - sel_b;
            2'b10:   alu_res = sel_a & sel_b;
            default: alu_res = sel_a | sel_b;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        prio_d     = prio_q;
        res_data_d = res_data_q;
        res_id_d   = res_id_q;
        if (req_xfer) begin
            // A request that arrives with a result transfer refills the register.
            state_d    = FULL;
            prio_d     = req0_xfer;   // the requester that lost goes first next time
            res_data_d = alu_res;
            res_id_d   = req1_xfer;
        end else if (res_xfer) begin
            state_d = EMPTY;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= EMPTY;
            prio_q     <= 1'b0;
            res_data_q <= '0;
            res_id_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            prio_q     <= prio_d;
            res_data_q <= res_data_d;
            res_id_q   <= res_id_d;
        end
    end

    assign res_data = res_data_q;
    assign res_id   = res_id_q;

`ifdef ALU_ARBITER_FLAGS_EN
    logic res_carry_q, res_carry_d, res_zero_q, res_zero_d, alu_carry;

    // A wrapped sum is smaller than either operand exactly when the add carries.
    always_comb begin
        alu_carry = 1'b0;
        case (sel_op)
            2'b00:   alu_carry = (alu_res < sel_a);
            2'b01:   alu_carry = (sel_a < sel_b);
            default: alu_carry = 1'b0;
        endcase
        res_carry_d = res_carry_q;
        res_zero_d  = res_zero_q;
        if (req_xfer) begin
            res_carry_d = alu_carry;
            res_zero_d  = (alu_res == '0);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            res_carry_q <= 1'b0;
            res_zero_q  <= 1'b0;
        end else begin
            res_carry_q <= res_carry_d;
            res_zero_q  <= res_zero_d;
        end
    end

    assign res_carry = res_carry_q;
    assign res_zero  = res_zero_q;
`endif

endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter (WIDTH=4). It applies a table of vectors,
// one per clock, and then runs a hand-written asynchronous-reset sequence.
module tb_alu_arbiter;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       req0_valid, req1_valid, req0_ready, req1_ready;
    logic [3:0] req0_a, req0_b, req1_a, req1_b;
    logic [1:0] req0_op, req1_op;
    logic       res_valid, res_ready, res_id;
    logic [3:0] res_data;
`ifdef ALU_ARBITER_FLAGS_EN
    logic       res_carry, res_zero;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    alu_arbiter #(.WIDTH(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_ready(req0_ready),
        .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op),
        .req1_valid(req1_valid), .req1_ready(req1_ready),
        .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op),
        .res_valid(res_valid), .res_ready(res_ready),
        .res_data(res_data), .res_id(res_id)
`ifdef ALU_ARBITER_FLAGS_EN
        , .res_carry(res_carry), .res_zero(res_zero)
`endif
    );

    typedef struct {
        logic       v0;  logic [3:0] a0; logic [3:0] b0; logic [1:0] op0;
        logic       v1;  logic [3:0] a1; logic [3:0] b1; logic [1:0] op1;
        logic       rr;
        logic       er0; logic er1;            // expected readies before the edge
        logic       erv;                       // expected res_valid after the edge
        logic       chk;                       // check data/id/flags after the edge
        logic [3:0] ed;  logic eid; logic ec; logic ez;
    } vec_t;

    vec_t vecs[19];

    function automatic vec_t mk(logic v0, logic [3:0] a0, logic [3:0] b0, logic [1:0] op0,
                                logic v1, logic [3:0] a1, logic [3:0] b1, logic [1:0] op1,
                                logic rr, logic er0, logic er1, logic erv, logic chk,
                                logic [3:0] ed, logic eid, logic ec, logic ez);
        vec_t v;
        v.v0 = v0; v.a0 = a0; v.b0 = b0; v.op0 = op0;
        v.v1 = v1; v.a1 = a1; v.b1 = b1; v.op1 = op1;
        v.rr = rr; v.er0 = er0; v.er1 = er1; v.erv = erv; v.chk = chk;
        v.ed = ed; v.eid = eid; v.ec = ec; v.ez = ez;
        return v;
    endfunction

    task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s [%0d] got %0h expected %0h", name, idx, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        req0_valid = v.v0; req0_a = v.a0; req0_b = v.b0; req0_op = v.op0;
        req1_valid = v.v1; req1_a = v.a1; req1_b = v.b1; req1_op = v.op1;
        res_ready  = v.rr;
    endtask

    initial begin
        //            v0 a0    b0    op0    v1 a1    b1    op1    rr er0 er1 erv chk ed    id ec ez
        vecs[0]  = mk(1, 4'h3, 4'h5, 2'b00, 0, 4'h0, 4'h0, 2'b00, 0, 1, 0, 1, 1, 4'h8, 0, 0, 0); // first request
        vecs[1]  = mk(0, 4'h0, 4'h0, 2'b00, 1, 4'h2, 4'h5, 2'b01, 1, 0, 1, 1, 1, 4'hD, 1, 1, 0); // wrap subtract
        vecs[2]  = mk(0, 4'h0, 4'h0, 2'b00, 0, 4'h0, 4'h0, 2'b00, 1, 0, 0, 0, 0, 4'h0, 0, 0, 0); // drain
        vecs[3]  = mk(1, 4'hA, 4'h6, 2'b10, 0, 4'h0, 4'h0, 2'b00, 0, 1, 0, 1, 1, 4'h2, 0, 0, 0); // AND
        vecs[4]  = mk(0, 4'h0, 4'h0, 2'b00, 1, 4'hA, 4'h6, 2'b11, 0, 0, 0, 1, 1, 4'h2, 0, 0, 0); // stall
        vecs[5]  = mk(0, 4'h0, 4'h0, 2'b00, 1, 4'hA, 4'h6, 2'b11, 1, 0, 1, 1, 1, 4'hE, 1, 0, 0); // OR
        vecs[6]  = mk(1, 4'h5, 4'hA, 2'b10, 0, 4'h0, 4'h0, 2'b00, 1, 1, 0, 1, 1, 4'h0, 0, 0, 1); // AND to zero
        vecs[7]  = mk(0, 4'h0, 4'h0, 2'b00, 1, 4'h1, 4'h1, 2'b00, 1, 0, 1, 1, 1, 4'h2, 1, 0, 0); // pointer -> 0
        vecs[8]  = mk(1, 4'h1, 4'h2, 2'b00, 1, 4'h7, 4'h1, 2'b01, 1, 1, 0, 1, 1, 4'h3, 0, 0, 0); // contention
        vecs[9]  = mk(1, 4'h1, 4'h2, 2'b00, 1, 4'h7, 4'h1, 2'b01, 1, 0, 1, 1, 1, 4'h6, 1, 0, 0);
        vecs[10] = mk(1, 4'h1, 4'h2, 2'b00, 1, 4'h7, 4'h1, 2'b01, 1, 1, 0, 1, 1, 4'h3, 0, 0, 0);
        vecs[11] = mk(1, 4'h1, 4'h2, 2'b00, 1, 4'h7, 4'h1, 2'b01, 1, 0, 1, 1, 1, 4'h6, 1, 0, 0);
        vecs[12] = mk(1, 4'h1, 4'h2, 2'b00, 1, 4'h7, 4'h1, 2'b01, 0, 0, 0, 1, 1, 4'h6, 1, 0, 0); // backpressure x3
        vecs[13] = mk(1, 4'h1, 4'h2, 2'b00, 1, 4'h7, 4'h1, 2'b01, 0, 0, 0, 1, 1, 4'h6, 1, 0, 0);
        vecs[14] = mk(1, 4'h1, 4'h2, 2'b00, 1, 4'h7, 4'h1, 2'b01, 0, 0, 0, 1, 1, 4'h6, 1, 0, 0);
        vecs[15] = mk(1, 4'h1, 4'h2, 2'b00, 1, 4'h7, 4'h1, 2'b01, 1, 1, 0, 1, 1, 4'h3, 0, 0, 0); // release
        vecs[16] = mk(0, 4'h0, 4'h0, 2'b00, 0, 4'h0, 4'h0, 2'b00, 1, 0, 0, 0, 0, 4'h0, 0, 0, 0);
        vecs[17] = mk(1, 4'hF, 4'h1, 2'b00, 0, 4'h0, 4'h0, 2'b00, 1, 1, 0, 1, 1, 4'h0, 0, 1, 1); // add carry
        vecs[18] = mk(0, 4'h0, 4'h0, 2'b00, 1, 4'h0, 4'h0, 2'b01, 1, 0, 1, 1, 1, 4'h0, 1, 0, 1); // 0-0

        // Reset with a requester already valid: nothing may be granted.
        rst_n = 1'b0;
        drive(mk(1, 4'h3, 4'h5, 2'b00, 1, 4'h1, 4'h1, 2'b00, 1, 0, 0, 0, 0, 4'h0, 0, 0, 0));
        repeat (2) @(posedge clk);
        #1;
        chk("rst_res_valid", -1, res_valid, 0);
        chk("rst_res_data", -1, res_data, 0);
        chk("rst_res_id", -1, res_id, 0);
        chk("rst_req0_ready", -1, req0_ready, 0);
        chk("rst_req1_ready", -1, req1_ready, 0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 19; i++) begin
            if (i != 0) @(negedge clk);
            drive(vecs[i]);
            #1;
            chk("req0_ready", i, req0_ready, vecs[i].er0);
            chk("req1_ready", i, req1_ready, vecs[i].er1);
            @(posedge clk);
            #1;
            chk("res_valid", i, res_valid, vecs[i].erv);
            if (vecs[i].chk) begin
                chk("res_data", i, res_data, vecs[i].ed);
                chk("res_id", i, res_id, vecs[i].eid);
`ifdef ALU_ARBITER_FLAGS_EN
                chk("res_carry", i, res_carry, vecs[i].ec);
                chk("res_zero", i, res_zero, vecs[i].ez);
`endif
            end
        end

        // Asynchronous reset while FULL, asserted between edges.
        @(negedge clk);
        drive(mk(1, 4'h1, 4'h1, 2'b00, 1, 4'h2, 4'h2, 2'b00, 0, 0, 0, 0, 0, 4'h0, 0, 0, 0));
        #1;
        chk("pre_arst_full", 100, res_valid, 1);
        #1;
        rst_n = 1'b0;
        #1;
        chk("arst_res_valid", 100, res_valid, 0);
        chk("arst_res_data", 100, res_data, 0);
        chk("arst_req0_ready", 100, req0_ready, 0);
        chk("arst_req1_ready", 100, req1_ready, 0);
        @(negedge clk);
        rst_n = 1'b1;
        res_ready = 1'b1;
        #1;
        // The pointer restarts at requester 0 even though requester 1 won last.
        chk("post_rst_req0_ready", 101, req0_ready, 1);
        chk("post_rst_req1_ready", 101, req1_ready, 0);
        @(posedge clk);
        #1;
        chk("post_rst_res_valid", 101, res_valid, 1);
        chk("post_rst_res_data", 101, res_data, 4'h2);
        chk("post_rst_res_id", 101, res_id, 0);
        @(negedge clk);
        #1;
        chk("post_rst_rr_req1_ready", 102, req1_ready, 1);
        @(posedge clk);
        #1;
        chk("post_rst_rr_res_data", 102, res_data, 4'h4);
        chk("post_rst_rr_res_id", 102, res_id, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 Parameter WIDTH, default 4, operand/result width in bits.
REQ-002 clk  input  1  rising-edge clock.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 req0_valid / req1_valid  input  1 each  requester 0/1 has an operation pending.
REQ-005 req0_ready / req1_ready  output  1 each  requester 0/1 request accepted this cycle.
REQ-006 req0_a, req0_b / req1_a, req1_b  input  WIDTH each  operands A and B.
REQ-007 req0_op / req1_op  input  2 each  operation: 00 add, 01 subtract, 10 AND, 11 OR.
REQ-008 res_valid  output  1  result register holds an unconsumed result.
REQ-009 res_ready  input  1  consumer accepts the result.
REQ-010 res_data  output  WIDTH  registered result.
REQ-011 res_id  output  1  requester index that owns res_data.

Function
REQ-012 Transfer rules: a request transfers when reqN_valid and reqN_ready are both high at a rising edge; a result transfers when res_valid and res_ready are both high.
REQ-013 States: EMPTY (res_valid=0) and FULL (res_valid=1).
- EMPTY to FULL on any request transfer.
- FULL to EMPTY on a result transfer with no request transfer.
- FULL stays FULL when a result transfer and a request transfer occur in the same cycle.
REQ-014 The block SHALL accept a request only when in EMPTY, or in FULL with res_ready=1, giving one result per cycle under continuous demand.
REQ-015 At most one of req0_ready and req1_ready SHALL be high in any cycle, and reqN_ready SHALL never be high while reqN_valid is low.
REQ-016 Arbitration is round-robin.
- One valid requester is granted.
- When both are valid, the requester not granted by the last transfer is granted.
- After reset, requester 0 has priority.
- The priority pointer updates only on a request transfer.
REQ-017 Computation is modulo 2^WIDTH.
- 00: A+B, carry discarded.
- 01: A-B in two's complement, borrow discarded.
- 10: bitwise AND.
- 11: bitwise OR.
REQ-018 Latency: a request transferring at edge N SHALL present its result and res_id from edge N until its result transfer.
REQ-019 res_data and res_id SHALL hold stable while res_valid=1 and res_ready=0.
REQ-020 reqN_ready SHALL be combinational from the valid inputs, res_ready and state; no ready output SHALL depend on operand or op inputs.

Reset
REQ-021 While rst_n=0 the outputs SHALL be held as follows, independent of clk:
- state=EMPTY, res_valid=0, res_data=0, res_id=0.
- priority pointer set to requester 0.
- req0_ready=0, req1_ready=0.
REQ-022 A reset asserted mid-operation SHALL discard any held result and any request presented in that cycle; no transfer SHALL be reported.
REQ-023 The first transfer SHALL be possible at the first rising edge after rst_n deasserts.

Configuration
REQ-024 When macro ALU_ARBITER_FLAGS_EN is defined, outputs res_carry (1 bit) and res_zero (1 bit) SHALL exist.
- res_carry: carry-out for add, borrow (A<B unsigned) for subtract, 0 for logic ops.
- res_zero: result equal to 0.
- Both are registered with res_data and follow the same reset and hold rules.
REQ-025 When ALU_ARBITER_FLAGS_EN is undefined, these ports and their logic SHALL be absent, and all other behaviour SHALL be identical.

Verification
REQ-026 Reset then a single request: req0 A=3, B=5, op=00 -> req0_ready=1 in the same cycle; next cycle res_valid=1, res_data=8, res_id=0.
REQ-027 Wrap: req1 A=2, B=5, op=01 -> res_data=13, res_id=1; with flags, res_carry=1 and res_zero=0.
REQ-028 Contention: both requesters valid for 4 cycles with res_ready=1 -> grants alternate 0,1,0,1 and results are back-to-back at 1 per cycle.
REQ-029 Backpressure: hold res_ready=0 for 3 cycles while FULL -> both reqN_ready=0 and res_data/res_id stable; on res_ready=1, a transfer and a new accept occur in the same cycle.
REQ-030 Logic ops: A=0xA, B=0x6 -> op=10 gives 0x2, op=11 gives 0xE; A=0x5, B=0xA, op=10 -> 0x0, res_zero=1.
REQ-031 Asynchronous reset while FULL, between clock edges -> res_valid=0 immediately; after release with both requesters valid, requester 0 is granted first.
